// File: rtl/seg2_scan_ctrl.sv
// Two-digit multiplexed 7-segment scan driver paced by a synchronised 100 kHz strobe.
// Optional build macro SEG2_LEAD_ZERO_BLANK_EN blanks the segments of a leading-zero tens digit.
module seg2_scan_ctrl #(
    parameter int SCAN_DIV    = 100,
    parameter int BLANK_TICKS = 2,
    parameter int SEG_INV     = 0,
    parameter int DIG_INV     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_100khz,
    input  logic [7:0] bcd_in,
    input  logic [1:0] dp_in,
    output logic [7:0] seg,
    output logic [1:0] dig,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        BLANK_U = 2'd0,
        SHOW_U  = 2'd1,
        BLANK_T = 2'd2,
        SHOW_T  = 2'd3
    } state_t;

    // With no blanking the scan starts, and restarts each frame, directly on the units digit.
    localparam state_t     START_STATE = (BLANK_TICKS == 0) ? SHOW_U : BLANK_U;
    localparam logic [8:0] SHOW_LAST   = 9'(SCAN_DIV - 1);
    localparam logic [8:0] BLANK_LAST  = (BLANK_TICKS == 0) ? 9'd0 : 9'(BLANK_TICKS - 1);
    localparam logic [7:0] SEG_MASK    = (SEG_INV != 0) ? 8'hFF : 8'h00;
    localparam logic [1:0] DIG_MASK    = (DIG_INV != 0) ? 2'b11 : 2'b00;

    function automatic logic [6:0] decode7(input logic [3:0] value);
        case (value)
            4'd0:    decode7 = 7'h3F;
            4'd1:    decode7 = 7'h06;
            4'd2:    decode7 = 7'h5B;
            4'd3:    decode7 = 7'h4F;
            4'd4:    decode7 = 7'h66;
            4'd5:    decode7 = 7'h6D;
            4'd6:    decode7 = 7'h7D;
            4'd7:    decode7 = 7'h07;
            4'd8:    decode7 = 7'h7F;
            4'd9:    decode7 = 7'h6F;
            default: decode7 = 7'h40;
        endcase
    endfunction

    logic       sync1, sync2, sync3;
    logic       tick;
    state_t     state_q, state_d;
    logic [8:0] cnt_q;
    logic [8:0] limit;
    logic       frame_end;
    logic       primed_q;
    logic [7:0] bcd_lat;
    logic [1:0] dp_lat;
    logic [7:0] bcd_view;
    logic [1:0] dp_view;
    logic [7:0] seg_nxt;
    logic [1:0] dig_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= clk_100khz;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign tick = sync2 & ~sync3;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        frame_end = 1'b0;
        limit     = (state_q == SHOW_U || state_q == SHOW_T) ? SHOW_LAST : BLANK_LAST;
        if (tick && cnt_q == limit) begin
            case (state_q)
                BLANK_U: state_d = SHOW_U;
                SHOW_U:  state_d = (BLANK_TICKS == 0) ? SHOW_T : BLANK_T;
                BLANK_T: state_d = SHOW_T;
                SHOW_T: begin
                    state_d   = START_STATE;
                    frame_end = 1'b1;
                end
                default: state_d = START_STATE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= START_STATE;
            cnt_q   <= 9'd0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= 9'd0;
            end else if (tick) begin
                cnt_q <= cnt_q + 9'd1;
            end
        end
    end

    // Display data is captured once after reset and then only at frame boundaries,
    // so both digits of a frame always come from the same value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed_q <= 1'b0;
            bcd_lat  <= 8'h00;
            dp_lat   <= 2'b00;
        end else begin
            primed_q <= 1'b1;
            if (!primed_q || frame_end) begin
                bcd_lat <= bcd_in;
                dp_lat  <= dp_in;
            end
        end
    end

    // Bypass covers the single clock before the first capture lands.
    assign bcd_view = primed_q ? bcd_lat : bcd_in;
    assign dp_view  = primed_q ? dp_lat  : dp_in;

    always_comb begin
        seg_nxt = 8'h00;
        dig_nxt = 2'b00;
        case (state_q)
            SHOW_U: begin
                dig_nxt = 2'b01;
                seg_nxt = {dp_view[0], decode7(bcd_view[3:0])};
            end
            SHOW_T: begin
                dig_nxt = 2'b10;
                seg_nxt = {dp_view[1], decode7(bcd_view[7:4])};
`ifdef SEG2_LEAD_ZERO_BLANK_EN
                if (bcd_view[7:4] == 4'd0) begin
                    seg_nxt[6:0] = 7'h00;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_MASK;
            dig        <= DIG_MASK;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_nxt ^ SEG_MASK;
            dig        <= dig_nxt ^ DIG_MASK;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg2_scan_ctrl.sv
// Scoreboard bench for seg2_scan_ctrl: expected display phases are queued per frame and
// compared as the outputs change; a second instance covers the no-blanking, inverted build.
module tb_seg2_scan_ctrl;

    localparam int SCAN_DIV    = 6;
    localparam int BLANK_TICKS = 2;
    localparam int HALF_CLK    = 4;
    localparam int TICK_CLK    = 2 * HALF_CLK;
    localparam int SHOW_CLK    = SCAN_DIV * TICK_CLK;
    localparam int BLANK_CLK   = BLANK_TICKS * TICK_CLK;
    localparam int FRAME_CLK   = 2 * (SHOW_CLK + BLANK_CLK);
    localparam int HOLD_CLK    = 200;
    localparam int SCAN_DIV2   = 4;

    typedef struct {
        logic [1:0] dig;
        logic [7:0] seg;
        int         len;
    } phase_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_100khz = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] bcd_in = 8'h00;
    logic [1:0] dp_in = 2'b00;
    logic [7:0] seg;
    logic [1:0] dig;
    logic       frame_done;

    logic       rst2_n = 1'b0;
    logic [7:0] bcd2 = 8'h05;
    logic [1:0] dp2 = 2'b00;
    logic [7:0] seg2;
    logic [1:0] dig2;
    logic       fd2;

    phase_t     exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         pcnt = 0;
    int         div_cnt = 0;
    int         start_cnt = 0;
    int         last_fd = 0;
    bit         have_fd = 1'b0;
    bit         fd_prev = 1'b0;
    bit         sb_on = 1'b1;
    logic [9:0] prev_out;

    seg2_scan_ctrl #(
        .SCAN_DIV(SCAN_DIV), .BLANK_TICKS(BLANK_TICKS), .SEG_INV(0), .DIG_INV(0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .clk_100khz(clk_100khz), .bcd_in(bcd_in),
        .dp_in(dp_in), .seg(seg), .dig(dig), .frame_done(frame_done)
    );

    seg2_scan_ctrl #(
        .SCAN_DIV(SCAN_DIV2), .BLANK_TICKS(0), .SEG_INV(1), .DIG_INV(1)
    ) u_dut_nb (
        .clk(clk), .rst_n(rst2_n), .clk_100khz(clk_100khz), .bcd_in(bcd2),
        .dp_in(dp2), .seg(seg2), .dig(dig2), .frame_done(fd2)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic logic [7:0] units_seg(input logic [7:0] b, input logic [1:0] d);
        return {d[0], dec7(b[3:0])};
    endfunction

    function automatic logic [7:0] tens_seg(input logic [7:0] b, input logic [1:0] d);
        logic [6:0] s;
        s = dec7(b[7:4]);
`ifdef SEG2_LEAD_ZERO_BLANK_EN
        if (b[7:4] == 4'd0) s = 7'h00;
`endif
        return {d[1], s};
    endfunction

    // Strobe generator and output monitor share one negedge process so the non-hold
    // cycle count and the phase boundaries are sampled in a fixed order.
    always @(negedge clk) begin
        phase_t e;
        int     len;
        if (rst_n !== 1'b1) begin
            prev_out  = {dig, seg};
            start_cnt = pcnt;
            have_fd   = 1'b0;
            fd_prev   = 1'b0;
        end else begin
            if ({dig, seg} !== prev_out) begin
                len = pcnt - start_cnt;
                if (sb_on) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL phase_unexpected: ended dig=%b seg=%h len=%0d, none expected",
                                 prev_out[9:8], prev_out[7:0], len);
                    end else begin
                        e = exp_q.pop_front();
                        if (prev_out[9:8] !== e.dig || prev_out[7:0] !== e.seg ||
                            (e.len != 0 && len != e.len)) begin
                            errors++;
                            $display("FAIL phase: got dig=%b seg=%h len=%0d, want dig=%b seg=%h len=%0d",
                                     prev_out[9:8], prev_out[7:0], len, e.dig, e.seg, e.len);
                        end
                    end
                    checks++;
                    if (dig === 2'b11) begin
                        errors++;
                        $display("FAIL dig_onehot: got dig=%b, want one-hot or zero", dig);
                    end
                end
                prev_out  = {dig, seg};
                start_cnt = pcnt;
            end
            if (frame_done === 1'b1) begin
                checks++;
                if (dig !== 2'b10 || fd_prev) begin
                    errors++;
                    $display("FAIL frame_done_align: got dig=%b prev_fd=%0d, want dig=10 prev_fd=0",
                             dig, fd_prev);
                end
                if (have_fd) begin
                    checks++;
                    if (pcnt - last_fd != FRAME_CLK) begin
                        errors++;
                        $display("FAIL frame_period: got %0d clk, want %0d clk", pcnt - last_fd, FRAME_CLK);
                    end
                end
                last_fd = pcnt;
                have_fd = 1'b1;
            end
            fd_prev = (frame_done === 1'b1);
        end
        if (!hold) begin
            pcnt++;
            div_cnt++;
            if (div_cnt == HALF_CLK) begin
                div_cnt    = 0;
                clk_100khz = ~clk_100khz;
            end
        end
    end

    task automatic wait_dig(input logic [1:0] v, input int budget, input string name);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (dig === v) break;
        end
        checks++;
        if (n == budget) begin
            errors++;
            $display("FAIL %s: timeout, got dig=%b, want dig=%b", name, dig, v);
        end
    endtask

    task automatic wait_fd(input int budget, input string name);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (frame_done === 1'b1) break;
        end
        checks++;
        if (n == budget) begin
            errors++;
            $display("FAIL %s: timeout, got no frame_done within %0d clk", name, budget);
        end
    endtask

    // Queue one frame of expected phases for the latched value b/d, then drive the value
    // the next frame must show while the units digit of this frame is lit.
    task automatic run_frame(input bit first, input logic [7:0] b, input logic [1:0] d,
                             input logic [7:0] nb, input logic [1:0] nd, input bit do_hold,
                             input string name);
        logic [7:0] snap_seg;
        logic [1:0] snap_dig;
        bit         frozen;
        bit         fd_seen;
        int         n;
        exp_q.push_back('{dig: 2'b00, seg: 8'h00, len: first ? 0 : BLANK_CLK});
        exp_q.push_back('{dig: 2'b01, seg: units_seg(b, d), len: SHOW_CLK});
        exp_q.push_back('{dig: 2'b00, seg: 8'h00, len: BLANK_CLK});
        exp_q.push_back('{dig: 2'b10, seg: tens_seg(b, d), len: SHOW_CLK});
        wait_dig(2'b01, FRAME_CLK + 100, name);
        bcd_in = nb;
        dp_in  = nd;
        if (do_hold) begin
            repeat (10) @(negedge clk);
            for (n = 0; n < 20; n++) begin
                @(posedge clk);
                if (clk_100khz === 1'b1) break;
            end
            hold = 1'b1;
            @(negedge clk);
            snap_seg = seg;
            snap_dig = dig;
            frozen   = 1'b1;
            fd_seen  = 1'b0;
            repeat (HOLD_CLK - 1) begin
                @(negedge clk);
                if (seg !== snap_seg || dig !== snap_dig) frozen = 1'b0;
                if (frame_done === 1'b1) fd_seen = 1'b1;
            end
            @(posedge clk);
            hold = 1'b0;
            checks++;
            if (!frozen || fd_seen || snap_dig !== 2'b01) begin
                errors++;
                $display("FAIL hold_freeze: got frozen=%0d fd_seen=%0d dig=%b, want frozen=1 fd_seen=0 dig=01",
                         frozen, fd_seen, snap_dig);
            end
        end
        wait_fd(FRAME_CLK + HOLD_CLK + 100, name);
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: got %0d phases not shown, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (seg !== 8'h00 || dig !== 2'b00 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_main: got seg=%h dig=%b fd=%b, want seg=00 dig=00 fd=0",
                         seg, dig, frame_done);
            end
            checks++;
            if (seg2 !== 8'hFF || dig2 !== 2'b11 || fd2 !== 1'b0) begin
                errors++;
                $display("FAIL reset_inv: got seg=%h dig=%b fd=%b, want seg=ff dig=11 fd=0",
                         seg2, dig2, fd2);
            end
        end
        bcd_in = 8'h42;
        dp_in  = 2'b00;
        rst_n  = 1'b1;
        rst2_n = 1'b1;
    endtask

    task automatic test_scan();
        run_frame(1'b1, 8'h42, 2'b00, 8'h42, 2'b00, 1'b0, "scan_first");
        run_frame(1'b0, 8'h42, 2'b00, 8'h17, 2'b00, 1'b0, "scan_steady");
    endtask

    task automatic test_no_tearing();
        run_frame(1'b0, 8'h17, 2'b00, 8'hB3, 2'b10, 1'b0, "new_value");
    endtask

    task automatic test_dash_dp();
        run_frame(1'b0, 8'hB3, 2'b10, 8'h0A, 2'b01, 1'b0, "dash_dp");
    endtask

    task automatic test_hold();
        run_frame(1'b0, 8'h0A, 2'b01, 8'h99, 2'b11, 1'b1, "hold");
        run_frame(1'b0, 8'h99, 2'b11, 8'h99, 2'b11, 1'b0, "after_hold");
        sb_on = 1'b0;
    endtask

    task automatic test_blank0();
        int n;
        int len;
        bit fd_seen;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (dig2 === 2'b01) break;
        end
        checks++;
        if (n == 200) begin
            errors++;
            $display("FAIL nb_tens_wait: timeout, got dig=%b, want dig=01", dig2);
        end
        repeat (2) @(negedge clk);
        rst2_n = 1'b0;
        #1;
        checks++;
        if (seg2 !== 8'hFF || dig2 !== 2'b11 || fd2 !== 1'b0) begin
            errors++;
            $display("FAIL nb_async_reset: got seg=%h dig=%b fd=%b, want seg=ff dig=11 fd=0",
                     seg2, dig2, fd2);
        end
        repeat (3) @(negedge clk);
        rst2_n = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (dig2 !== 2'b11) break;
        end
        checks++;
        if (dig2 !== 2'b10 || seg2 !== ~units_seg(8'h05, 2'b00)) begin
            errors++;
            $display("FAIL nb_first_units: got dig=%b seg=%h, want dig=10 seg=%h",
                     dig2, seg2, ~units_seg(8'h05, 2'b00));
        end
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (dig2 !== 2'b10) break;
        end
        checks++;
        if (dig2 !== 2'b01 || seg2 !== ~tens_seg(8'h05, 2'b00)) begin
            errors++;
            $display("FAIL nb_tens: got dig=%b seg=%h, want dig=01 seg=%h",
                     dig2, seg2, ~tens_seg(8'h05, 2'b00));
        end
        len     = 0;
        fd_seen = 1'b0;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            len++;
            if (fd2 === 1'b1) fd_seen = 1'b1;
            if (dig2 !== 2'b01) break;
        end
        checks++;
        if (dig2 !== 2'b10 || len != SCAN_DIV2 * TICK_CLK || !fd_seen) begin
            errors++;
            $display("FAIL nb_wrap: got dig=%b len=%0d fd=%0d, want dig=10 len=%0d fd=1",
                     dig2, len, fd_seen, SCAN_DIV2 * TICK_CLK);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_no_tearing();
        test_dash_dp();
        test_hold();
        test_blank0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
